// File: rtl/burst_pulse_gen_if.sv
// Control/status bundle for the programmable pulse-burst generator.
interface burst_pulse_gen_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned REP_W = 4
);
    logic             start;
    logic             abort;
    logic [1:0]       mode;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] gap;
    logic [REP_W-1:0] reps;
    logic             out;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [REP_W-1:0] burst_idx;

    // Requester side: issues commands, observes status
    modport master (
        output start, abort, mode, len, gap, reps,
        input  out, busy, done, aborted, burst_idx
    );

    // Generator side
    modport slave (
        input  start, abort, mode, len, gap, reps,
        output out, busy, done, aborted, burst_idx
    );
endinterface

// File: rtl/burst_pulse_gen.sv
// Programmable pulse-burst generator: LEN high cycles, GAP low cycles,
// repeated once, REPS times or continuously until aborted.
module burst_pulse_gen #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned REP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    burst_pulse_gen_if.slave   bus
);
    localparam int unsigned IDX_XW = REP_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [REP_W-1:0] idx, idx_n;
    logic [CNT_W-1:0] len_q, gap_q;
    logic [REP_W-1:0] reps_q;
    logic             cont_q, multi_q;
    logic             out_q, busy_q, done_q, aborted_q;
    logic             load, done_n, aborted_n, more;
    logic [IDX_XW-1:0] idx_inc;

    // Another burst follows: continuous always, repeat mode while bursts remain
    always_comb begin
        idx_inc = {1'b0, idx} + IDX_XW'(1);
        more    = cont_q | (multi_q & (idx_inc < {1'b0, reps_q}));
    end

    // Next-state, counter and status-pulse decode
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        load      = 1'b0;
        done_n    = 1'b0;
        aborted_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start && !bus.abort && (bus.len != '0)) begin
                    load    = 1'b1;
                    state_n = S_HIGH;
                    cnt_n   = CNT_W'(bus.len - CNT_W'(1));
                    idx_n   = '0;
                end
            end
            S_HIGH: begin
                if (bus.abort) begin
                    state_n   = S_IDLE;
                    cnt_n     = '0;
                    aborted_n = 1'b1;
                end else if (cnt == '0) begin
                    if (more) begin
                        if (gap_q != '0) begin
                            state_n = S_GAP;
                            cnt_n   = CNT_W'(gap_q - CNT_W'(1));
                        end else begin
                            cnt_n = CNT_W'(len_q - CNT_W'(1));
                            idx_n = REP_W'(idx_inc);
                        end
                    end else begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end
                end else begin
                    cnt_n = CNT_W'(cnt - CNT_W'(1));
                end
            end
            S_GAP: begin
                if (bus.abort) begin
                    state_n   = S_IDLE;
                    cnt_n     = '0;
                    aborted_n = 1'b1;
                end else if (cnt == '0) begin
                    state_n = S_HIGH;
                    cnt_n   = CNT_W'(len_q - CNT_W'(1));
                    idx_n   = REP_W'(idx_inc);
                end else begin
                    cnt_n = CNT_W'(cnt - CNT_W'(1));
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // State, counters, latched run parameters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            reps_q    <= '0;
            cont_q    <= 1'b0;
            multi_q   <= 1'b0;
            out_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            out_q     <= (state_n == S_HIGH);
            busy_q    <= (state_n != S_IDLE);
            done_q    <= done_n;
            aborted_q <= aborted_n;
            if (load) begin
                len_q   <= bus.len;
                gap_q   <= bus.gap;
                // reps of zero runs a single burst
                reps_q  <= (bus.reps == '0) ? REP_W'(1) : bus.reps;
                cont_q  <= (bus.mode == 2'b10);
                multi_q <= (bus.mode == 2'b01);
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;
    assign bus.burst_idx = idx;
endmodule

// File: tb/tb_burst_pulse_gen.sv
// Directed bench for burst_pulse_gen: vector table plus corner-case sequences.
module tb_burst_pulse_gen;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned REP_W = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    burst_pulse_gen_if #(.CNT_W(CNT_W), .REP_W(REP_W)) bus ();

    burst_pulse_gen #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        int         len;
        int         gap;
        int         reps;
        int         abort_at;   // 0-based active cycle during which abort is held, -1 = none
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.mode  = 2'b00;
        bus.len   = '0;
        bus.gap   = '0;
        bus.reps  = '0;
    endtask

    // Apply one vector; expected waveform from closed-form period arithmetic
    task automatic run_vec(input int vi, input vec_t v);
        int nb, total, last, per, ph, exp_idx;
        bit is_abort;
        string tag;
        if (v.mode == 2'b01)      nb = (v.reps == 0) ? 1 : v.reps;
        else if (v.mode == 2'b10) nb = 1000;
        else                      nb = 1;
        total    = nb * v.len + (nb - 1) * v.gap;
        is_abort = (v.abort_at >= 0) && (v.abort_at < total);
        last     = is_abort ? v.abort_at + 1 : total;
        per      = v.len + v.gap;

        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = v.mode;
        bus.len   = CNT_W'(v.len);
        bus.gap   = CNT_W'(v.gap);
        bus.reps  = REP_W'(v.reps);
        @(negedge clk);
        for (int t = 0; t <= last + 1; t++) begin
            tag = $sformatf("v%0d t%0d", vi, t);
            if (t < last) begin
                ph      = t % per;
                exp_idx = (t / per) % 16;
                chk({tag, " out"},  int'(bus.out), (ph < v.len) ? 1 : 0);
                chk({tag, " busy"}, int'(bus.busy), 1);
                chk({tag, " idx"},  int'(bus.burst_idx), exp_idx);
                chk({tag, " done"}, int'(bus.done), 0);
            end else begin
                chk({tag, " out"},     int'(bus.out), 0);
                chk({tag, " busy"},    int'(bus.busy), 0);
                chk({tag, " done"},    int'(bus.done), (t == last && !is_abort) ? 1 : 0);
                chk({tag, " aborted"}, int'(bus.aborted), (t == last && is_abort) ? 1 : 0);
            end
            // Disturb inputs while running: re-start and parameter changes must be ignored
            bus.abort = (t == v.abort_at);
            bus.start = (t == 1) && (t < last);
            bus.mode  = 2'($urandom_range(0, 3));
            bus.len   = CNT_W'($urandom_range(1, 255));
            bus.gap   = CNT_W'($urandom_range(0, 255));
            bus.reps  = REP_W'($urandom_range(0, 15));
            if (t >= last) idle_inputs();
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_inputs();

        vecs[0] = '{mode: 2'b00, len: 16,  gap: 5, reps: 7, abort_at: -1};
        vecs[1] = '{mode: 2'b01, len: 3,   gap: 2, reps: 3, abort_at: -1};
        vecs[2] = '{mode: 2'b01, len: 4,   gap: 0, reps: 2, abort_at: -1};
        vecs[3] = '{mode: 2'b10, len: 2,   gap: 1, reps: 0, abort_at: 9};
        vecs[4] = '{mode: 2'b11, len: 1,   gap: 0, reps: 0, abort_at: -1};
        vecs[5] = '{mode: 2'b01, len: 2,   gap: 1, reps: 0, abort_at: -1};
        vecs[6] = '{mode: 2'b01, len: 1,   gap: 1, reps: 4, abort_at: -1};
        vecs[7] = '{mode: 2'b10, len: 1,   gap: 0, reps: 0, abort_at: 40};
        vecs[8] = '{mode: 2'b01, len: 255, gap: 0, reps: 1, abort_at: -1};

        #12;
        chk("rst out",  int'(bus.out), 0);
        chk("rst busy", int'(bus.busy), 0);
        chk("rst done", int'(bus.done), 0);
        chk("rst abrt", int'(bus.aborted), 0);
        chk("rst idx",  int'(bus.burst_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Ignored requests in IDLE: zero length, and start together with abort
        @(negedge clk);
        bus.start = 1'b1; bus.len = '0; bus.mode = 2'b01; bus.reps = 4'd3;
        @(negedge clk);
        chk("len0 busy", int'(bus.busy), 0);
        chk("len0 out",  int'(bus.out), 0);
        bus.len = 8'd5; bus.abort = 1'b1;
        @(negedge clk);
        chk("st+ab busy", int'(bus.busy), 0);
        chk("st+ab abrt", int'(bus.aborted), 0);
        idle_inputs();
        bus.abort = 1'b1;
        @(negedge clk);
        chk("idle ab abrt", int'(bus.aborted), 0);
        chk("idle ab busy", int'(bus.busy), 0);
        idle_inputs();

        // Back-to-back: start in the done cycle gives exactly one low cycle
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 2'b00; bus.len = 8'd2;
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b c0 out", int'(bus.out), 1);
        @(negedge clk);
        chk("b2b c1 out", int'(bus.out), 1);
        @(negedge clk);
        chk("b2b c2 out",  int'(bus.out), 0);
        chk("b2b c2 done", int'(bus.done), 1);
        bus.start = 1'b1; bus.len = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b c3 out",  int'(bus.out), 1);
        chk("b2b c3 busy", int'(bus.busy), 1);
        chk("b2b c3 done", int'(bus.done), 0);
        repeat (2) @(negedge clk);
        chk("b2b c5 out", int'(bus.out), 1);
        @(negedge clk);
        chk("b2b c6 out",  int'(bus.out), 0);
        chk("b2b c6 done", int'(bus.done), 1);
        idle_inputs();
        @(negedge clk);

        // Asynchronous reset in the middle of a repeat run
        bus.start = 1'b1; bus.mode = 2'b01; bus.len = 8'd10; bus.gap = 8'd0; bus.reps = 4'd3;
        @(negedge clk);
        idle_inputs();
        repeat (12) @(negedge clk);
        chk("mid idx", int'(bus.burst_idx), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst out",  int'(bus.out), 0);
        chk("arst busy", int'(bus.busy), 0);
        chk("arst idx",  int'(bus.burst_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            chk($sformatf("post rst done t%0d", t), int'(bus.done), 0);
            chk($sformatf("post rst busy t%0d", t), int'(bus.busy), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
